// File: rtl/dpram_rd_port.sv
// Read-side controller for the dual-port RAM: credit-gated request accept, registered
// array read, same-cycle write bypass, and a 3-entry in-order return FIFO.
module dpram_rd_port #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          RD_REQ,
    input  logic [AW-1:0] RD_ADDR,
    output logic          RD_ACK,
    output logic          MEM_RE,
    output logic [AW-1:0] MEM_RADDR,
    input  logic [DW-1:0] MEM_RDATA,
    input  logic          WR_EN,
    input  logic [AW-1:0] WR_ADDR,
    input  logic [DW-1:0] WR_DATA,
    output logic          RD_VALID,
    output logic [DW-1:0] RD_DATA,
    input  logic          RD_READY
);
    localparam int DEPTH = 3;
    typedef logic [1:0] ptr_t;

    logic          s1_q, s1_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic          pend_q, pend_d;
    ptr_t          pend_idx_q, pend_idx_d;
    logic          byp_q, byp_d;
    logic [DW-1:0] byp_data_q, byp_data_d;
    ptr_t          rd_ptr_q, rd_ptr_d;
    ptr_t          wr_ptr_q, wr_ptr_d;
    logic [1:0]    count_q, count_d;
    logic [DW-1:0] fifo_q [DEPTH];

    logic          accept;
    logic          push;
    logic          pop;
    logic          byp_hit;
    logic [DW-1:0] pend_word;
    logic [DW-1:0] head_word;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? ptr_t'(0) : ptr_t'(p + 2'd1);
    endfunction

    assign MEM_RE    = s1_q;
    assign MEM_RADDR = raddr_q;
    assign RD_VALID  = (count_q != 2'd0);

    // A slot is reserved at the end of the MEM_RE cycle; its word arrives on MEM_RDATA
    // (or from the bypass latch) one cycle later and is shown directly if it is the head.
    always_comb begin
        RD_ACK     = (3'(s1_q) + 3'(count_q)) < 3'd3;
        accept     = RD_REQ && RD_ACK;
        push       = s1_q;
        pop        = RD_VALID && RD_READY;
        byp_hit    = s1_q && WR_EN && (WR_ADDR == raddr_q);
        pend_word  = byp_q ? byp_data_q : MEM_RDATA;
        head_word  = (pend_q && (pend_idx_q == rd_ptr_q)) ? pend_word : fifo_q[rd_ptr_q];
        RD_DATA    = RD_VALID ? head_word : '0;

        s1_d       = accept;
        raddr_d    = accept ? RD_ADDR : raddr_q;
        pend_d     = push;
        pend_idx_d = wr_ptr_q;
        byp_d      = byp_hit;
        byp_data_d = byp_hit ? WR_DATA : byp_data_q;
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d    = count_q + 2'(push) - 2'(pop);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_q       <= 1'b0;
            raddr_q    <= '0;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            s1_q       <= s1_d;
            raddr_q    <= raddr_d;
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
            byp_q      <= byp_d;
            byp_data_q <= byp_data_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // NOTE: the storage has no reset; RD_DATA is masked to zero until a valid head exists.
    always_ff @(posedge CLK) begin
        if (pend_q) begin
            fifo_q[pend_idx_q] <= pend_word;
        end
    end

endmodule
